param_column_shift_loader: RTL and testbench
============================================

Name: param_column_shift_loader

Overview:
- Parametrised successor to the fixed 22x22 column shift loader that drives the compressor under test.
- Serially loads a triangular partial-product bit matrix: 2N-1 columns, column c of height h(c)=min(c+1, 2N-1-c).
- Adds what the fixed loader lacks: synchronous reset/clear, a fill counter with a `full` flag, and a LATENCY-aligned capture of the compressor result with a valid pulse.
- Sits between the bench stimulus and the compressor; presents a flat column bus out and captures the 2N-bit compressor output back.

Parameters:
N, 22, operand width; columns = 2N-1, max column height = N, total matrix bits = N*N, result width = 2N.
LATENCY, 0, pipeline depth of the compressor in cycles, 0..16. 0 means a combinational compressor.
FILL_W, $clog2(N+1), width of fill_count.

Ports:
clk  in  1  rising-edge clock.
rst  in  1  synchronous, active-high reset.
clear  in  1  synchronous clear of the matrix, counter and result pipeline; same effect as rst.
shift_en  in  1  shift one new bit into every column this cycle.
src_in  in  2N-1  new bit per column; bit c feeds column c.
col_bits  out  N*N  packed matrix to the compressor.
  - Column c occupies [OFF(c)+h(c)-1 : OFF(c)], where OFF(c) = sum of h(k) for k<c.
  - Within a column, bit 0 is the newest.
fill_count  out  FILL_W  number of shifts since reset/clear, saturating at N.
full  out  1  fill_count == N.
dst_in  in  2N  compressor result.
result  out  2N  captured compressor result.
result_valid  out  1  one-cycle pulse when `result` updates.

Behaviour:
- Reset values: on rst or clear, all of the following are 0.
  - col_bits, fill_count, full.
  - result, result_valid.
  - Internal valid pipeline.
- rst and clear are equivalent, and both take priority over shift_en in the same cycle.
- Shift: when shift_en=1, every column c takes {col[h(c)-2:0], src_in[c]}.
  - Height-1 columns simply load src_in[c].
  - The oldest bit falls off the top.
- shift_en=0: matrix holds.
- fill_count:
  - Increments on each shift_en while < N, then saturates at N.
  - Does not wrap.
  - full is registered and consistent with fill_count in the same cycle.
- Window-fresh event: asserted in the cycle after a shift_en in which the resulting fill_count == N, i.e. col_bits now holds a fully populated new window.
  - Successive shifts while full each generate one event.
- Result capture:
  - The fresh event is delayed by exactly LATENCY cycles through a LATENCY-deep valid shift register.
  - When the delayed event is seen, `result` <= dst_in on that edge, and result_valid = 1 for the following cycle.
  - LATENCY=0: capture on the edge that ends the fresh cycle, so result_valid rises 1 cycle after col_bits updates.
  - General rule: result_valid rises LATENCY+1 cycles after the col_bits update.
- Back-to-back shifts while full produce back-to-back result_valid pulses. There is no backpressure and no dropping.
- `result` holds its value between pulses.
- Reset or clear mid-pipeline discards all in-flight events: no result_valid until a new full window is loaded.
- Unused output widths: none. All widths derive from N; for N=1, col_bits is 1 bit and result is 2 bits.
- No combinational path from src_in to col_bits; col_bits is a pure register output.

Test Plan:
1. N=4, LATENCY=0. Reset, then 4 shifts with src_in=7'b1111111.
   - col_bits=16'hFFFF.
   - fill_count steps 1,2,3,4; full rises with the 4th update.
   - First result_valid 1 cycle after the 4th update.
2. N=4. Shift src_in=7'b0000001, then three shifts of 0.
   - Column 0 = 1'b0.
   - Column-3 slice [9:6] = 4'b0000; column 0 bit history lost (height 1).
   - Repeat with only bit 3 set on the first shift: after 4 shifts, col_bits[9] (oldest bit of column 3) = 1.
3. N=4, LATENCY=3. Fill 4 shifts, then 2 more consecutive shifts; bench drives dst_in=8'hA5,8'h3C aligned to the delayed events.
   - result_valid pulses 4 cycles after each col_bits update, back-to-back.
   - result = 8'hA5 then 8'h3C.
4. N=4, LATENCY=3. Full window; assert clear 1 cycle after the fresh event.
   - No result_valid follows.
   - col_bits=0, fill_count=0, full=0 the cycle after clear.
5. N=4. Assert clear and shift_en in the same cycle with src_in all ones.
   - col_bits=0, fill_count=0: clear wins.
   - Repeat using rst instead of clear: identical response.
6. N=22, LATENCY=0. 30 random shifts.
   - col_bits matches a reference model of 43 columns with heights 1..22..1.
   - fill_count saturates at 22.
   - result_valid count = 30-21 = 9.

Source files
------------

// File: rtl/param_column_shift_loader.sv
// Serial loader for a triangular partial-product matrix feeding a compressor,
// with fill tracking and a latency-aligned capture of the compressor result.
module param_column_shift_loader #(
  parameter int N       = 22,
  parameter int LATENCY = 0,
  parameter int FILL_W  = $clog2(N + 1)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                clear,
  input  logic                shift_en,
  input  logic [2*N-2:0]      src_in,
  output logic [N*N-1:0]      col_bits,
  output logic [FILL_W-1:0]   fill_count,
  output logic                full,
  input  logic [2*N-1:0]      dst_in,
  output logic [2*N-1:0]      result,
  output logic                result_valid
);

  localparam int COLS = 2 * N - 1;
  localparam logic [FILL_W-1:0] FILL_MAX = FILL_W'(N);

  function automatic int col_h(input int c);
    return (c + 1 < COLS - c) ? c + 1 : COLS - c;
  endfunction

  function automatic int col_off(input int c);
    int s;
    s = 0;
    for (int k = 0; k < c; k++) s += col_h(k);
    return s;
  endfunction

  logic [N*N-1:0]    col_q, col_d, col_shift;
  logic [FILL_W-1:0] fill_q, fill_d;
  logic              full_q, full_d;
  logic [LATENCY:0]  evt_q, evt_d;
  logic [2*N-1:0]    result_q, result_d;
  logic              rvalid_q, rvalid_d;
  logic              flush;

  assign flush = rst | clear;

  // Each column shifts its newest bit in at position 0; the top bit drops out.
  for (genvar c = 0; c < COLS; c++) begin : g_col
    localparam int H   = col_h(c);
    localparam int OFF = col_off(c);
    if (H == 1) begin : g_h1
      assign col_shift[OFF] = src_in[c];
    end else begin : g_hn
      assign col_shift[OFF+H-1:OFF] = {col_q[OFF+H-2:OFF], src_in[c]};
    end
  end

  always_comb begin
    col_d    = col_q;
    fill_d   = fill_q;
    if (shift_en) begin
      col_d = col_shift;
      if (fill_q != FILL_MAX) fill_d = fill_q + FILL_W'(1);
    end
    full_d   = (fill_d == FILL_MAX);
    // evt_d[0] marks a freshly completed window; higher taps track the compressor delay.
    evt_d[0] = shift_en & (fill_d == FILL_MAX);
    for (int k = 1; k <= LATENCY; k++) evt_d[k] = evt_q[k-1];
    rvalid_d = evt_q[LATENCY];
    result_d = evt_q[LATENCY] ? dst_in : result_q;
  end

  always_ff @(posedge clk) begin
    if (flush) begin
      col_q    <= '0;
      fill_q   <= '0;
      full_q   <= 1'b0;
      evt_q    <= '0;
      result_q <= '0;
      rvalid_q <= 1'b0;
    end else begin
      col_q    <= col_d;
      fill_q   <= fill_d;
      full_q   <= full_d;
      evt_q    <= evt_d;
      result_q <= result_d;
      rvalid_q <= rvalid_d;
    end
  end

  assign col_bits     = col_q;
  assign fill_count   = fill_q;
  assign full         = full_q;
  assign result       = result_q;
  assign result_valid = rvalid_q;

endmodule

// File: tb/tb_param_column_shift_loader.sv
// Bench for param_column_shift_loader: three configurations (N=4/L=0, N=4/L=3,
// N=22/L=0) checked every cycle against a shift-history model plus literal pins.
module tb_param_column_shift_loader;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic [2:0]  rst_v, clear_v, shift_v;
  logic [42:0] src_a [3];
  logic [43:0] dst_a [3];

  logic [15:0]  col0, col1;
  logic [483:0] col2;
  logic [2:0]   fill0, fill1;
  logic [4:0]   fill2;
  logic [2:0]   full_v, val_v;
  logic [7:0]   res0, res1;
  logic [43:0]  res2;

  param_column_shift_loader #(.N(4), .LATENCY(0)) u_a (
    .clk(clk), .rst(rst_v[0]), .clear(clear_v[0]), .shift_en(shift_v[0]),
    .src_in(src_a[0][6:0]), .col_bits(col0), .fill_count(fill0), .full(full_v[0]),
    .dst_in(dst_a[0][7:0]), .result(res0), .result_valid(val_v[0]));

  param_column_shift_loader #(.N(4), .LATENCY(3)) u_b (
    .clk(clk), .rst(rst_v[1]), .clear(clear_v[1]), .shift_en(shift_v[1]),
    .src_in(src_a[1][6:0]), .col_bits(col1), .fill_count(fill1), .full(full_v[1]),
    .dst_in(dst_a[1][7:0]), .result(res1), .result_valid(val_v[1]));

  param_column_shift_loader #(.N(22), .LATENCY(0)) u_c (
    .clk(clk), .rst(rst_v[2]), .clear(clear_v[2]), .shift_en(shift_v[2]),
    .src_in(src_a[2]), .col_bits(col2), .fill_count(fill2), .full(full_v[2]),
    .dst_in(dst_a[2]), .result(res2), .result_valid(val_v[2]));

  int nn  [3] = '{4, 4, 22};
  int lat [3] = '{0, 3, 0};

  int checks   = 0;
  int failures = 0;
  bit ena      = 1'b0;

  // Model: the last 22 shifted-in src vectors, shift count, and scheduled capture edges.
  logic [42:0] mh   [3][22];
  int          mcnt [3];
  int          pend [3][$];
  logic [43:0] mres [3];
  logic        mval [3];
  int          medge = 0;

  initial begin
    for (int k = 0; k < 3; k++) begin
      mcnt[k] = 0; mres[k] = '0; mval[k] = 1'b0;
      for (int j = 0; j < 22; j++) mh[k][j] = '0;
    end
  end

  always @(posedge clk) begin
    medge++;
    for (int k = 0; k < 3; k++) begin
      if (rst_v[k] || clear_v[k]) begin
        mcnt[k] = 0;
        for (int j = 0; j < 22; j++) mh[k][j] = '0;
        pend[k].delete();
        mres[k] = '0;
        mval[k] = 1'b0;
      end else begin
        mval[k] = 1'b0;
        if (pend[k].size() > 0 && pend[k][0] == medge) begin
          void'(pend[k].pop_front());
          mval[k] = 1'b1;
          mres[k] = dst_a[k] & ((44'd1 << (2 * nn[k])) - 44'd1);
        end
        if (shift_v[k]) begin
          for (int j = 21; j > 0; j--) mh[k][j] = mh[k][j-1];
          mh[k][0] = src_a[k];
          mcnt[k]++;
          if (mcnt[k] >= nn[k]) pend[k].push_back(medge + lat[k] + 1);
        end
      end
    end
  end

  function automatic logic [483:0] exp_col(input int k);
    logic [483:0] v;
    int n, off, h;
    v = '0; n = nn[k]; off = 0;
    for (int c = 0; c < 2 * n - 1; c++) begin
      h = (c + 1 < 2 * n - 1 - c) ? c + 1 : 2 * n - 1 - c;
      for (int j = 0; j < h; j++)
        if (j < mcnt[k]) v[off + j] = mh[k][j][c];
      off += h;
    end
    return v;
  endfunction

  task automatic chk(input string name, input logic [483:0] act, input logic [483:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  task automatic cmp_inst(input int k, input logic [483:0] ac, input logic [4:0] af,
                          input logic afull, input logic [43:0] ar, input logic av);
    int ef;
    ef = (mcnt[k] >= nn[k]) ? nn[k] : mcnt[k];
    chk($sformatf("col_bits[%0d]", k), ac, exp_col(k));
    chk($sformatf("fill_count[%0d]", k), 484'(af), 484'(ef));
    chk($sformatf("full[%0d]", k), 484'(afull), 484'(ef == nn[k]));
    chk($sformatf("result[%0d]", k), 484'(ar), 484'(mres[k]));
    chk($sformatf("result_valid[%0d]", k), 484'(av), 484'(mval[k]));
  endtask

  always @(negedge clk) begin
    if (ena) begin
      cmp_inst(0, 484'(col0), 5'(fill0), full_v[0], 44'(res0), val_v[0]);
      cmp_inst(1, 484'(col1), 5'(fill1), full_v[1], 44'(res1), val_v[1]);
      cmp_inst(2, col2, fill2, full_v[2], res2, val_v[2]);
    end
  end

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  int vcount;

  initial begin
    rst_v = 3'b111; clear_v = '0; shift_v = '0;
    for (int k = 0; k < 3; k++) begin src_a[k] = '0; dst_a[k] = '0; end
    tick(); tick();
    rst_v = '0;
    ena = 1'b1;

    // Fill with all ones, N=4 L=0
    chk("t1_reset_col", 484'(col0), 484'd0);
    chk("t1_reset_fill", 484'(fill0), 484'd0);
    chk("t1_reset_valid", 484'(val_v[0]), 484'd0);
    dst_a[0] = 44'h5A;
    for (int i = 0; i < 4; i++) begin
      shift_v[0] = 1'b1; src_a[0] = 43'h7F;
      tick();
      chk("t1_fill_step", 484'(fill0), 484'(i + 1));
      chk("t1_full", 484'(full_v[0]), 484'(i == 3));
      chk("t1_no_valid_yet", 484'(val_v[0]), 484'd0);
    end
    chk("t1_col_all_ones", 484'(col0), 484'h FFFF);
    shift_v[0] = 1'b0;
    tick();
    chk("t1_first_valid", 484'(val_v[0]), 484'd1);
    chk("t1_result", 484'(res0), 484'h5A);

    // Single-bit walk, N=4
    clear_v[0] = 1'b1; tick(); clear_v[0] = 1'b0;
    shift_v[0] = 1'b1; src_a[0] = 43'h01; tick();
    src_a[0] = '0; tick(); tick(); tick();
    shift_v[0] = 1'b0;
    chk("t2_col0_bit", 484'(col0[0]), 484'd0);
    chk("t2_col3_slice", 484'(col0[9:6]), 484'd0);
    clear_v[0] = 1'b1; tick(); clear_v[0] = 1'b0;
    shift_v[0] = 1'b1; src_a[0] = 43'h08; tick();
    src_a[0] = '0; tick(); tick(); tick();
    shift_v[0] = 1'b0;
    chk("t2_col3_oldest", 484'(col0[9]), 484'd1);
    chk("t2_col_whole", 484'(col0), 484'h0200);

    // Back-to-back results through LATENCY=3
    rst_v[1] = 1'b1; tick(); rst_v[1] = 1'b0;
    for (int t = 1; t <= 12; t++) begin
      shift_v[1] = (t <= 6);
      src_a[1]   = 43'($urandom);
      dst_a[1]   = (t == 8) ? 44'h11 : (t == 9) ? 44'hA5 : (t == 10) ? 44'h3C : 44'h00;
      tick();
      if (t == 7 || t == 11) chk("t3_valid_low", 484'(val_v[1]), 484'd0);
      if (t >= 8 && t <= 10) chk("t3_valid_high", 484'(val_v[1]), 484'd1);
      if (t == 9)  chk("t3_result_a5", 484'(res1), 484'hA5);
      if (t == 10) chk("t3_result_3c", 484'(res1), 484'h3C);
      if (t == 12) chk("t3_result_hold", 484'(res1), 484'h3C);
    end

    // Clear while an event is in flight
    rst_v[1] = 1'b1; tick(); rst_v[1] = 1'b0;
    for (int t = 1; t <= 12; t++) begin
      shift_v[1] = (t <= 4);
      clear_v[1] = (t == 6);
      src_a[1]   = 43'h7F;
      dst_a[1]   = 44'hFF;
      tick();
      if (t == 6) begin
        chk("t4_col_cleared", 484'(col1), 484'd0);
        chk("t4_fill_cleared", 484'(fill1), 484'd0);
        chk("t4_full_cleared", 484'(full_v[1]), 484'd0);
      end
      if (t >= 6) chk("t4_no_valid", 484'(val_v[1]), 484'd0);
    end
    clear_v[1] = 1'b0;

    // Clear/rst beat shift_en in the same cycle
    shift_v[0] = 1'b1; src_a[0] = 43'h7F; tick(); tick();
    clear_v[0] = 1'b1; tick(); clear_v[0] = 1'b0;
    chk("t5_clear_col", 484'(col0), 484'd0);
    chk("t5_clear_fill", 484'(fill0), 484'd0);
    tick(); tick();
    rst_v[0] = 1'b1; tick(); rst_v[0] = 1'b0;
    chk("t5_rst_col", 484'(col0), 484'd0);
    chk("t5_rst_fill", 484'(fill0), 484'd0);
    shift_v[0] = 1'b0;

    // 30 random shifts into the full-size matrix
    rst_v[2] = 1'b1; tick(); rst_v[2] = 1'b0;
    vcount = 0;
    for (int t = 1; t <= 32; t++) begin
      shift_v[2] = (t <= 30);
      src_a[2]   = 43'({$urandom, $urandom});
      dst_a[2]   = 44'({$urandom, $urandom});
      tick();
      if (val_v[2]) vcount++;
    end
    shift_v[2] = 1'b0;
    chk("t6_fill_sat", 484'(fill2), 484'd22);
    chk("t6_valid_count", 484'(vcount), 484'd9);

    // Free-running random traffic on every instance
    for (int t = 0; t < 300; t++) begin
      for (int k = 0; k < 3; k++) begin
        shift_v[k] = ($urandom_range(0, 3) != 0);
        clear_v[k] = ($urandom_range(0, 40) == 0);
        rst_v[k]   = ($urandom_range(0, 60) == 0);
        src_a[k]   = 43'({$urandom, $urandom});
        dst_a[k]   = 44'({$urandom, $urandom});
      end
      tick();
    end
    shift_v = '0; clear_v = '0; rst_v = '0;
    tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
